retire_freelist: RTL and testbench
==================================

# retire_freelist

Consumer of the ROB retire interface. Accepts up to two retired ROB rows per cycle, returns each retiring instruction's superseded physical register (`OldPRegAddrDst`) to a circular free list, and hands free physical registers to rename at up to two per cycle. Sits between the complete/retire stage and the rename/dispatch stage, closing the physical-register loop.

## Interface
Parameters:
- `NUM_PREGS`, 64: physical registers; `preg_t` width is `$clog2(NUM_PREGS)` = 6.
- `NUM_AREGS`, 32: architectural registers; free-list depth `FL_DEPTH = NUM_PREGS - NUM_AREGS` = 32.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `i_clk  in  1`: clock.
  - `i_rst  in  1`: asynchronous, active-high reset.
- Retire side:
  - `i_retire_rows [0:1]  in  rob_row_struct`: retired rows; slot 0 is older.
- Rename side:
  - `i_alloc_req [0:1]  in  1`: rename requests a register; slot 0 is older.
  - `o_alloc_valid [0:1]  out  1`: grant, combinational.
  - `o_alloc_preg [0:1]  out  preg_t`: granted register, combinational.
- Status:
  - `o_free_count  out  6`: free-list occupancy, 0..32.
  - `o_overflow  out  1`: sticky error.
  - `o_commit_count  out  32`: retired-instruction count.
  - `o_store_count  out  32`: retired-store count.

## Operation
- **Retire qualification.** A row retires only when `valid==1 && complete==1`. Upstream drives `valid=0` on idle slots.
- **Push.** A push happens when the row retires, `RegWrite==1` and `OldPRegAddrDst != 0`. Physical register 0 is permanently mapped to x0 and is never freed.
  - Slot 0 is written at `tail` and slot 1 after it.
  - `tail` advances by the number of pushes, modulo 32.
- **Pop.**
  - Slot 0 is granted when `i_alloc_req[0] && count>=1`.
  - Slot 1 is granted when `i_alloc_req[1] && count >= 1 + grant0`.
  - `o_alloc_preg[0] = fl[head]`.
  - `o_alloc_preg[1] = fl[head + grant0]`.
  - `head` advances by `grant0 + grant1`, modulo 32.
  - Partial grant is legal: slot 0 can be granted while slot 1 is denied. Slot 1 is never granted ahead of a denied slot 0 when slot 0 requests.
- **Count.** `count_next = count + pushes - pops`.
- **Overflow.** A push that would make count exceed 32 is dropped and sets `o_overflow`. `o_overflow` clears only on reset.
- **Counters.**
  - `o_commit_count` increments by the number of retiring rows.
  - `o_store_count` increments by the number of retiring rows with `MemWrite==1`.
  - Both wrap at 2^32.

## Timing
- **Reset values.**
  - Free-list storage: `fl[i] = NUM_AREGS + i` (registers 32..63).
  - Pointers and count: `head=0`, `tail=0`, `count=32`.
  - Outputs: `o_overflow=0`, both counters 0.
  - Grants follow combinationally from the reset state: `o_alloc_valid` equals `i_alloc_req`, and `o_alloc_preg` = 32, 33.
- **Latency.** A freed register is allocatable the cycle after its retire. There is no same-cycle push-to-pop bypass: with count=0 and a simultaneous push, the grant is denied this cycle.
- **Grants.** Grants are combinational from registered `head` and `count`. Rename consumes a grant in the same cycle it is asserted.
- **Wrap-around.** The pointer wraps 31→0 correctly when two pushes or two pops straddle the boundary.
- **Mid-operation reset.** Reset during operation restores the full reset state immediately (asynchronously). Rows presented on the cycle reset deasserts are processed normally.

## Configuration
- `RETIRE_STATS_EN` defined:
  - `o_commit_count` and `o_store_count` registers are present.
- `RETIRE_STATS_EN` undefined:
  - Both ports are tied to 0 and no counter flops are built.
  - Free-list behaviour is identical either way.

## Structure
- `Types` package:
  - Add `preg_t` and constants `NUM_PREGS` and `NUM_AREGS`.
  - Reuse the existing `rob_row_struct`, using fields `valid`, `complete`, `RegWrite`, `MemWrite` and `OldPRegAddrDst`.
- Sub-module `freelist_fifo`:
  - 2-wide-push / 2-wide-pop circular buffer.
  - Holds storage, `head`, `tail` and `count`.
  - Reports overflow.
  - `retire_freelist` wraps it with the retire qualification, the grant logic and the counters.

## Test plan
- **Reset grants.** Reset, then `i_alloc_req={1,1}` for one cycle → grants 32, 33. The next cycle shows `o_free_count`=30.
- **Drain to empty.** Allocate 2 per cycle for 16 cycles → count=0. The next request gets `o_alloc_valid={0,0}`. A request with count=1 gets `{1,0}`.
- **Retire then allocate.** From count=0, retire rows with Old=5 and Old=7, `RegWrite=1`. The next cycle allocation returns 5, then 7. `o_commit_count` increases by 2.
- **Filtered retires.** Retire rows with `RegWrite=0`, Old=0, or `complete=0` → count is unchanged. `MemWrite=1` rows increment `o_store_count`.
- **Simultaneous push and pop.** Count=1, retire Old=9, request 2 in the same cycle → grant `{1,0}`. Count stays 1, and the next grant returns 9.
- **Overflow.** From reset (count=32), retire a row with Old=40 → the push is dropped, `o_overflow`=1 and stays 1 until `i_rst`.

Source files
------------

// File: rtl/retire_freelist_pkg.sv
// Shared types for the retire-side free list: physical register index and retired ROB row.
package retire_freelist_pkg;
   localparam int NUM_PREGS = 64;
   localparam int NUM_AREGS = 32;
   localparam int FL_DEPTH  = NUM_PREGS - NUM_AREGS;
   localparam int PREG_W    = $clog2(NUM_PREGS);
   localparam int PTR_W     = $clog2(FL_DEPTH);
   localparam int CNT_W     = $clog2(FL_DEPTH + 1);

   typedef logic [PREG_W-1:0] preg_t;

   typedef struct packed {
      logic  valid;
      logic  complete;
      logic  RegWrite;
      logic  MemWrite;
      preg_t OldPRegAddrDst;
   } rob_row_struct;
endpackage

// File: rtl/freelist_fifo.sv
// 2-wide push / 2-wide pop circular free list of physical registers.
// Pushes beyond capacity are dropped and latch a sticky overflow flag.
module freelist_fifo
   import retire_freelist_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       push_vld,
   input  preg_t [1:0]      push_preg,
   input  logic [1:0]       pop_num,
   output logic [CNT_W-1:0] count,
   output preg_t [1:0]      head_preg,
   output logic             overflow
);
   localparam int CW1 = CNT_W + 1;

   preg_t            fl_q [FL_DEPTH];
   preg_t            fl_d [FL_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [CW1-1:0]   room_base;
   logic             accept0, accept1;
   logic [1:0]       n_push;

   // Capacity is judged after this cycle's pops; pops never exceed count.
   always_comb begin
      fl_d       = fl_q;
      room_base  = {1'b0, count_q} - CW1'(pop_num);
      accept0    = push_vld[0] && (room_base < CW1'(FL_DEPTH));
      accept1    = push_vld[1] && ((room_base + CW1'(accept0)) < CW1'(FL_DEPTH));
      n_push     = {1'b0, accept0} + {1'b0, accept1};
      if (accept0) fl_d[tail_q] = push_preg[0];
      if (accept1) fl_d[tail_q + PTR_W'(accept0)] = push_preg[1];
      tail_d     = tail_q + PTR_W'(n_push);
      head_d     = head_q + PTR_W'(pop_num);
      count_d    = CNT_W'(room_base + CW1'(n_push));
      overflow_d = overflow_q | (push_vld[0] & ~accept0) | (push_vld[1] & ~accept1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= preg_t'(NUM_AREGS + i);
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= CNT_W'(FL_DEPTH);
         overflow_q <= 1'b0;
      end else begin
         fl_q       <= fl_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign count        = count_q;
   assign head_preg[0] = fl_q[head_q];
   assign head_preg[1] = fl_q[head_q + PTR_W'(1)];
   assign overflow     = overflow_q;
endmodule

// File: rtl/retire_freelist.sv
// Retire-side consumer closing the physical register loop: frees superseded pregs, grants them to rename.
// Define RETIRE_STATS_EN to build the commit/store counters; otherwise both counter ports read 0.
module retire_freelist
   import retire_freelist_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst,
   input  rob_row_struct i_retire_rows [0:1],
   input  logic          i_alloc_req   [0:1],
   output logic          o_alloc_valid [0:1],
   output preg_t         o_alloc_preg  [0:1],
   output logic [5:0]    o_free_count,
   output logic          o_overflow,
   output logic [31:0]   o_commit_count,
   output logic [31:0]   o_store_count
);
   logic [1:0]       retiring;
   logic [1:0]       push_vld;
   logic [1:0]       store;
   preg_t [1:0]      push_preg;
   preg_t [1:0]      head_preg;
   logic [CNT_W-1:0] count;
   logic             grant0, grant1;
   logic [1:0]       pop_num;

   // preg 0 is the permanent x0 mapping and must never re-enter the list.
   always_comb begin
      retiring  = '0;
      push_vld  = '0;
      store     = '0;
      push_preg = '0;
      for (int s = 0; s < 2; s++) begin
         retiring[s]  = i_retire_rows[s].valid && i_retire_rows[s].complete;
         push_vld[s]  = retiring[s] && i_retire_rows[s].RegWrite &&
                        (i_retire_rows[s].OldPRegAddrDst != '0);
         store[s]     = retiring[s] && i_retire_rows[s].MemWrite;
         push_preg[s] = i_retire_rows[s].OldPRegAddrDst;
      end
   end

   freelist_fifo u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .push_vld  (push_vld),
      .push_preg (push_preg),
      .pop_num   (pop_num),
      .count     (count),
      .head_preg (head_preg),
      .overflow  (o_overflow)
   );

   // Grants use registered state only, so a same-cycle push cannot be granted.
   always_comb begin
      grant0           = i_alloc_req[0] && (count != '0);
      grant1           = i_alloc_req[1] && (count > CNT_W'(grant0));
      pop_num          = {1'b0, grant0} + {1'b0, grant1};
      o_alloc_valid[0] = grant0;
      o_alloc_valid[1] = grant1;
      o_alloc_preg[0]  = head_preg[0];
      o_alloc_preg[1]  = grant0 ? head_preg[1] : head_preg[0];
   end

   assign o_free_count = count;

`ifdef RETIRE_STATS_EN
   logic [31:0] commit_q, commit_d;
   logic [31:0] store_q, store_d;

   always_comb begin
      commit_d = commit_q + 32'(retiring[0]) + 32'(retiring[1]);
      store_d  = store_q + 32'(store[0]) + 32'(store[1]);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         commit_q <= '0;
         store_q  <= '0;
      end else begin
         commit_q <= commit_d;
         store_q  <= store_d;
      end
   end

   assign o_commit_count = commit_q;
   assign o_store_count  = store_q;
`else
   logic unused_stats;
   assign unused_stats   = ^store;
   assign o_commit_count = '0;
   assign o_store_count  = '0;
`endif
endmodule

// File: tb/tb_retire_freelist.sv
// Scoreboard bench for retire_freelist: directed vectors queue expectations, a negedge monitor compares.
module tb_retire_freelist;
   import retire_freelist_pkg::*;

   typedef struct {
      string       name;
      logic        v0;
      logic        v1;
      logic [5:0]  p0;
      logic [5:0]  p1;
      logic [5:0]  cnt;
      logic        ovf;
      logic [31:0] commit;
      logic [31:0] store;
   } exp_t;

   logic          i_clk;
   logic          i_rst;
   rob_row_struct rows [0:1];
   logic          req  [0:1];
   logic          vld  [0:1];
   preg_t         preg [0:1];
   logic [5:0]    free_count;
   logic          overflow;
   logic [31:0]   commit_count;
   logic [31:0]   store_count;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_commit = 0;
   logic [31:0] exp_store  = 0;

   retire_freelist dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_retire_rows  (rows),
      .i_alloc_req    (req),
      .o_alloc_valid  (vld),
      .o_alloc_preg   (preg),
      .o_free_count   (free_count),
      .o_overflow     (overflow),
      .o_commit_count (commit_count),
      .o_store_count  (store_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   function automatic rob_row_struct mk(input logic v, input logic c, input logic rw,
                                        input logic mw, input logic [5:0] old);
      rob_row_struct r;
      r.valid          = v;
      r.complete       = c;
      r.RegWrite       = rw;
      r.MemWrite       = mw;
      r.OldPRegAddrDst = old;
      return r;
   endfunction

   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, expv);
      end
   endtask

   // One cycle: drive requests (rows already set), queue the expectation, advance.
   task automatic step(input string nm, input logic q0, input logic q1,
                       input logic ev0, input logic ev1,
                       input logic [5:0] ep0, input logic [5:0] ep1,
                       input logic [5:0] ecnt, input logic eovf);
      exp_t e;
      req[0]   = q0;
      req[1]   = q1;
      e.name   = nm;
      e.v0     = ev0;
      e.v1     = ev1;
      e.p0     = ep0;
      e.p1     = ep1;
      e.cnt    = ecnt;
      e.ovf    = eovf;
      e.commit = exp_commit;
      e.store  = exp_store;
      sb.push_back(e);
`ifdef RETIRE_STATS_EN
      for (int s = 0; s < 2; s++) begin
         if (rows[s].valid && rows[s].complete) begin
            exp_commit++;
            if (rows[s].MemWrite) exp_store++;
         end
      end
`endif
      @(posedge i_clk);
      #1;
      rows[0] = '0;
      rows[1] = '0;
      req[0]  = 1'b0;
      req[1]  = 1'b0;
   endtask

   always @(negedge i_clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk(mon_e.name, "valid0", 32'(vld[0]), 32'(mon_e.v0));
         chk(mon_e.name, "valid1", 32'(vld[1]), 32'(mon_e.v1));
         if (mon_e.v0) chk(mon_e.name, "preg0", 32'(preg[0]), 32'(mon_e.p0));
         if (mon_e.v1) chk(mon_e.name, "preg1", 32'(preg[1]), 32'(mon_e.p1));
         chk(mon_e.name, "free_count", 32'(free_count), 32'(mon_e.cnt));
         chk(mon_e.name, "overflow", 32'(overflow), 32'(mon_e.ovf));
         chk(mon_e.name, "commit", commit_count, mon_e.commit);
         chk(mon_e.name, "store", store_count, mon_e.store);
      end
   end

   initial begin
      i_rst   = 1'b1;
      rows[0] = '0;
      rows[1] = '0;
      req[0]  = 1'b0;
      req[1]  = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      step("rst_grant", 1, 1, 1, 1, 32, 33, 32, 0);
      for (int k = 0; k < 15; k++)
         step("drain", 1, 1, 1, 1, 6'(34 + 2*k), 6'(35 + 2*k), 6'(30 - 2*k), 0);
      step("empty", 1, 1, 0, 0, 0, 0, 0, 0);

      rows[0] = mk(1, 1, 1, 0, 5);
      rows[1] = mk(1, 1, 1, 0, 7);
      step("retire57", 0, 0, 0, 0, 0, 0, 0, 0);
      step("alloc5", 1, 0, 1, 0, 5, 0, 2, 0);
      step("cnt1_partial", 1, 1, 1, 0, 7, 0, 1, 0);

      rows[0] = mk(1, 1, 0, 1, 3);
      rows[1] = mk(1, 1, 1, 1, 0);
      step("filt_rw_x0", 0, 0, 0, 0, 0, 0, 0, 0);
      rows[0] = mk(1, 0, 1, 1, 4);
      rows[1] = mk(0, 1, 1, 1, 6);
      step("filt_incomplete", 1, 1, 0, 0, 0, 0, 0, 0);
      step("filt_idle", 1, 1, 0, 0, 0, 0, 0, 0);

      rows[1] = mk(1, 1, 1, 0, 11);
      step("slot1_push", 0, 0, 0, 0, 0, 0, 0, 0);
      rows[0] = mk(1, 1, 1, 0, 9);
      step("simul", 1, 1, 1, 0, 11, 0, 1, 0);
      step("simul_next", 1, 0, 1, 0, 9, 0, 1, 0);
      rows[0] = mk(1, 1, 1, 0, 12);
      step("no_bypass", 1, 0, 0, 0, 0, 0, 0, 0);
      step("slot1_only", 0, 1, 0, 1, 0, 12, 1, 0);

      rows[0] = mk(1, 1, 1, 0, 1);
      rows[1] = mk(1, 1, 1, 0, 2);
      step("wrap_fill", 0, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 15; k++) begin
         rows[0] = mk(1, 1, 1, 0, 6'(3 + 2*k));
         rows[1] = mk(1, 1, 1, 0, 6'(4 + 2*k));
         step("wrap", 1, 1, 1, 1, 6'(1 + 2*k), 6'(2 + 2*k), 2, 0);
      end
      step("wrap_tail", 1, 1, 1, 1, 31, 32, 2, 0);

      rows[0] = mk(1, 1, 1, 0, 50);
      step("pre_rst", 0, 0, 0, 0, 0, 0, 0, 0);
      i_rst      = 1'b1;
      exp_commit = 0;
      exp_store  = 0;
      step("async_rst", 1, 1, 1, 1, 32, 33, 32, 0);
      i_rst = 1'b0;

      rows[0] = mk(1, 1, 1, 1, 40);
      step("ovf_push", 0, 0, 0, 0, 0, 0, 32, 0);
      step("ovf_set", 0, 0, 0, 0, 0, 0, 32, 1);
      step("ovf_sticky", 1, 1, 1, 1, 32, 33, 32, 1);
      step("ovf_hold", 1, 0, 1, 0, 34, 0, 30, 1);

      i_rst      = 1'b1;
      exp_commit = 0;
      exp_store  = 0;
      step("rst_clr_ovf", 0, 0, 0, 0, 0, 0, 32, 0);
      i_rst = 1'b0;

      step("pop1", 1, 0, 1, 0, 32, 0, 32, 0);
      rows[0] = mk(1, 1, 1, 0, 20);
      rows[1] = mk(1, 1, 1, 0, 21);
      step("pair_push", 0, 0, 0, 0, 0, 0, 31, 0);
      step("pair_ovf", 0, 0, 0, 0, 0, 0, 32, 1);
      step("pair_after", 1, 1, 1, 1, 33, 34, 32, 1);

      @(negedge i_clk);
      #1;
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
